skinny_serial_ctrl: RTL and testbench
=====================================

Name: skinny_serial_ctrl

Overview:
- Control sequencer for the byte-serial Romulus/SKINNY-128-384 datapath, i.e. the mode_top datapath.
- Issues the per-cycle state-path and tweakey-path control words and round-constant bytes that the datapath consumes.
- Sequences one block-cipher call: load 16 bytes, run ROUNDS rounds, unload 16 bytes. Uses start/done towards the mode FSM and valid/ready towards the byte streams.

Parameters:
- ROUNDS, 40, number of SKINNY rounds per call (1..63).
- CYC_SB, 16, byte cycles per round in the SubCells/AddKey/ShiftRows phase.
- CYC_MX, 4, column cycles per round in the MixColumns phase.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a call; sampled only in IDLE
- pdi_valid  in  1  input byte present on datapath pdi
- pdi_ready  out  1  byte accepted this cycle (LOAD and pdi_valid)
- pdo_valid  out  1  output byte present on datapath pdo
- pdo_ready  in  1  downstream consumes pdo this cycle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last unloaded byte
- round  out  6  current round index, 0-based
- sen  out  4  state row shift enables (4'hF = shift, 4'h0 = hold)
- schain, smxc, smode, srst  out  1 each  state-path controls
- tk1se, tk1ksch, tk1chain, tk2ksch, tk2chain, tk3ksch, tk3chain  out  1 each  tweakey controls
- tk1s  out  1  subkey injection enable
- con  out  8  round-constant byte for the current cycle

Behaviour:
- FSM states are IDLE, LOAD, SB, MX and UNLOAD.
- Reset values:
  - All outputs are 0; the state is IDLE.
  - Internal counters cyc=0 and round=0; the LFSR rc=6'h00.
- IDLE:
  - On start, go to LOAD.
  - Assert srst for 1 cycle on the transition, which clears the datapath state.
  - Set rc=0 and round=0.
- LOAD:
  - pdi_ready=pdi_valid.
  - On each accepted byte: sen=4'hF, schain=1, cyc++.
  - With pdi_valid=0, sen=0 and all outputs hold.
  - After byte 15 is accepted: cyc=0, rc is stepped, and the FSM goes to SB.
- rc step: rc <= {rc[4:0], rc[5]^rc[4]^1}. Round 1 therefore uses 0x01.
- SB (CYC_SB cycles, no stall):
  - Held at 1 every cycle: sen=4'hF, schain=1.
  - tk1ksch, tk1chain, tk2ksch, tk2chain, tk3ksch and tk3chain are all 1 every cycle.
  - tk1s=1 for cyc 0..7 (rows 0-1 receive the subkey) and 0 otherwise.
  - con: cyc0 = {4'h0, rc[3:0]}; cyc4 = {6'h0, rc[5:4]}; cyc8 = 8'h02; all other cycles 8'h00.
  - At cyc=CYC_SB-1, go to MX and set cyc=0.
- MX (CYC_MX cycles):
  - smxc=1, sen=4'hF; the tweakey controls are 0 and con=0.
  - At the last cycle, if round==ROUNDS-1, go to UNLOAD.
  - Otherwise round++, step rc, and go to SB.
- UNLOAD:
  - pdo_valid=1.
  - Bytes shift only on pdo_valid&&pdo_ready: sen=4'hF, smode=1.
  - After the 16th handshake: pulse done for 1 cycle and go to IDLE. busy falls in the same cycle done is high.
- A start pulse while busy is ignored; no queuing.
- Simultaneous pdo_ready low in the final UNLOAD byte: stay in UNLOAD; done is not raised.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - Counters and rc are cleared; no done pulse.
- round is 6 bits and never wraps, because ROUNDS ≤ 63.
- cyc counter is 5 bits, sized for max(16, CYC_SB).

Optional Feature:
- Macro: SKINNY_DEC_EN.
- When the macro is defined:
  - Adds input port dec (1 bit), sampled with start.
  - With dec=1:
    - rc is loaded with 6'h1A (the round-40 constant) at start. It steps inversely after each round: rc <= {rc[0]^rc[5]^1, rc[5:1]}.
    - Each round runs MX before SB.
    - Adds output sdec, held at 1 throughout the call.
    - The tweakey chains run in inverse: tk*ksch=1, tk*chain=0.
  - With dec=0 the behaviour is identical to the build without the macro.
- When the macro is not defined: no dec or sdec ports, encryption only.

Test Plan:
- Reset with rst_n=0 mid-SB -> next cycle state IDLE, busy=0, con=0, sen=0; no done pulse.
- start, then 16 pdi bytes with pdi_valid held 1 -> pdi_ready high for 16 cycles; the first SB cycle has con=8'h01, cyc4 con=8'h00, cyc8 con=8'h02.
- Run to round index 5 -> SB cyc0 con=8'h0E, cyc4 con=8'h03 (rc=0x3E); round 39 cyc0 con=8'h0A, cyc4 con=8'h01 (rc=0x1A).
- pdi_valid toggled 1,0,1 in LOAD -> sen=4'hF, 0, 4'hF; cyc advances only on valid cycles; total LOAD length 16 accepted bytes.
- UNLOAD with pdo_ready low on byte 15 for 3 cycles -> pdo_valid stays 1, no done; done pulses 1 cycle after the 16th handshake. Full call with no stalls = 1+16+40*20+16 cycles.
- SKINNY_DEC_EN, dec=1 -> first SB phase con cyc0=8'h0A, cyc4=8'h01; the second round's rc=0x2D; sdec=1 throughout.

Source files
------------

// File: rtl/skinny_serial_ctrl_if.sv
// Handshake bundle between the mode FSM / byte streams and skinny_serial_ctrl.
interface skinny_serial_ctrl_if;
  logic start;
  logic done;
  logic busy;
  logic pdi_valid;
  logic pdi_ready;
  logic pdo_valid;
  logic pdo_ready;

  modport master (output start, pdi_valid, pdo_ready,
                  input  done, busy, pdi_ready, pdo_valid);
  modport slave  (input  start, pdi_valid, pdo_ready,
                  output done, busy, pdi_ready, pdo_valid);
endinterface

// File: rtl/skinny_serial_ctrl.sv
// Byte-serial SKINNY-128-384 control sequencer: load 16 bytes, ROUNDS x (SB, MX), unload 16 bytes.
// Decryption sequencing (MX before SB, inverse LFSR and tweakey chains) is built when SKINNY_DEC_EN is defined.
module skinny_serial_ctrl #(
  parameter int ROUNDS = 40,
  parameter int CYC_SB = 16,
  parameter int CYC_MX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  skinny_serial_ctrl_if.slave bus,
`ifdef SKINNY_DEC_EN
  input  logic                dec,
  output logic                sdec,
`endif
  output logic [5:0]          round,
  output logic [3:0]          sen,
  output logic                schain,
  output logic                smxc,
  output logic                smode,
  output logic                srst,
  output logic                tk1se,
  output logic                tk1ksch,
  output logic                tk1chain,
  output logic                tk2ksch,
  output logic                tk2chain,
  output logic                tk3ksch,
  output logic                tk3chain,
  output logic                tk1s,
  output logic [7:0]          con
);

  typedef enum logic [2:0] {IDLE, LOAD, SB, MX, UNLOAD} state_t;

  localparam logic [4:0] BYTE_LAST  = 5'd15;
  localparam logic [4:0] SB_LAST    = 5'(CYC_SB - 1);
  localparam logic [4:0] MX_LAST    = 5'(CYC_MX - 1);
  localparam logic [5:0] ROUND_LAST = 6'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [4:0] cyc_q, cyc_d;
  logic [5:0] round_q, round_d;
  logic [5:0] rc_q, rc_d;
  logic       done_q, done_d;
  logic       dec_q, dec_d;
  logic       dec_in_s;
  logic       pdi_ready_s, pdo_valid_s;

  function automatic logic [5:0] rc_fwd(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4] ^ 1'b1};
  endfunction

  function automatic logic [5:0] rc_inv(input logic [5:0] v);
    return {v[0] ^ v[5] ^ 1'b1, v[5:1]};
  endfunction

`ifdef SKINNY_DEC_EN
  assign dec_in_s = dec;
  assign sdec     = (state_q != IDLE) && dec_q;
`else
  assign dec_in_s = 1'b0;
`endif

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.pdi_ready = pdi_ready_s;
  assign bus.pdo_valid = pdo_valid_s;
  assign round         = round_q;

  // Next-state, counter/LFSR update and per-cycle control words
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    round_d     = round_q;
    rc_d        = rc_q;
    done_d      = 1'b0;
    dec_d       = dec_q;
    pdi_ready_s = 1'b0;
    pdo_valid_s = 1'b0;
    sen         = 4'h0;
    schain      = 1'b0;
    smxc        = 1'b0;
    smode       = 1'b0;
    srst        = 1'b0;
    tk1se       = 1'b0;
    tk1ksch     = 1'b0;
    tk1chain    = 1'b0;
    tk2ksch     = 1'b0;
    tk2chain    = 1'b0;
    tk3ksch     = 1'b0;
    tk3chain    = 1'b0;
    tk1s        = 1'b0;
    con         = 8'h00;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          srst    = 1'b1;
          cyc_d   = 5'd0;
          round_d = 6'd0;
          dec_d   = dec_in_s;
          rc_d    = dec_in_s ? 6'h1A : 6'h00;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        pdi_ready_s = bus.pdi_valid;
        if (bus.pdi_valid) begin
          sen    = 4'hF;
          schain = 1'b1;
          if (cyc_q == BYTE_LAST) begin
            cyc_d   = 5'd0;
            // decryption already starts from the last-round constant
            rc_d    = dec_q ? rc_q : rc_fwd(rc_q);
            state_d = dec_q ? MX : SB;
          end else begin
            cyc_d = cyc_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q;
        end
      end
      SB: begin
        sen      = 4'hF;
        schain   = 1'b1;
        tk1ksch  = 1'b1;
        tk2ksch  = 1'b1;
        tk3ksch  = 1'b1;
        tk1chain = ~dec_q;
        tk2chain = ~dec_q;
        tk3chain = ~dec_q;
        tk1s     = (cyc_q < 5'd8);
        if (cyc_q == 5'd0) begin
          con = {4'h0, rc_q[3:0]};
        end else if (cyc_q == 5'd4) begin
          con = {6'h00, rc_q[5:4]};
        end else if (cyc_q == 5'd8) begin
          con = 8'h02;
        end else begin
          con = 8'h00;
        end
        if (cyc_q == SB_LAST) begin
          cyc_d = 5'd0;
          if (!dec_q) begin
            state_d = MX;
          end else if (round_q == ROUND_LAST) begin
            state_d = UNLOAD;
          end else begin
            round_d = round_q + 6'd1;
            rc_d    = rc_inv(rc_q);
            state_d = MX;
          end
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      MX: begin
        smxc = 1'b1;
        sen  = 4'hF;
        if (cyc_q == MX_LAST) begin
          cyc_d = 5'd0;
          if (dec_q) begin
            state_d = SB;
          end else if (round_q == ROUND_LAST) begin
            state_d = UNLOAD;
          end else begin
            round_d = round_q + 6'd1;
            rc_d    = rc_fwd(rc_q);
            state_d = SB;
          end
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      UNLOAD: begin
        pdo_valid_s = 1'b1;
        if (bus.pdo_ready) begin
          sen   = 4'hF;
          smode = 1'b1;
          if (cyc_q == BYTE_LAST) begin
            cyc_d   = 5'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cyc_d = cyc_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, LFSR and done pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 5'd0;
      round_q <= 6'd0;
      rc_q    <= 6'h00;
      done_q  <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      round_q <= round_d;
      rc_q    <= rc_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
    end
  end

endmodule

// File: tb/tb_skinny_serial_ctrl.sv
// Randomized bench for skinny_serial_ctrl against a call-position model (load/compute/unload counts).
module tb_skinny_serial_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef SKINNY_DEC_EN
  localparam bit DEC_EN = 1'b1;
  logic dec, sdec;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  skinny_serial_ctrl_if bus_if();
  logic [5:0] round;
  logic [3:0] sen;
  logic schain, smxc, smode, srst, tk1se, tk1ksch, tk1chain;
  logic tk2ksch, tk2chain, tk3ksch, tk3chain, tk1s;
  logic [7:0] con;
  logic dec_drv;

  skinny_serial_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
`ifdef SKINNY_DEC_EN
    .dec(dec), .sdec(sdec),
`endif
    .round(round), .sen(sen), .schain(schain), .smxc(smxc), .smode(smode),
    .srst(srst), .tk1se(tk1se), .tk1ksch(tk1ksch), .tk1chain(tk1chain),
    .tk2ksch(tk2ksch), .tk2chain(tk2chain), .tk3ksch(tk3ksch),
    .tk3chain(tk3chain), .tk1s(tk1s), .con(con)
  );

`ifdef SKINNY_DEC_EN
  assign dec = dec_drv;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // model: phase 0 idle, 1 load, 2 compute (800 cycles), 3 unload
  int m_phase = 0, m_cnt = 0, m_round = 0;
  bit m_done = 1'b0, m_dec = 1'b0;
  logic [5:0] rc_enc [0:39];
  logic [5:0] rc_dec [0:39];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare process: expected outputs from the call position, then advance the model
  initial begin
    logic e_busy, e_done, e_pr, e_pv, e_schain, e_smxc, e_smode, e_srst;
    logic e_ksch, e_chain, e_tk1s;
    logic [3:0] e_sen;
    logic [5:0] e_round, rcv;
    logic [7:0] e_con;
    int r, p, sbi;
    bit in_mx;
    forever begin
      @(negedge clk);
      e_busy = 0; e_done = 0; e_pr = 0; e_pv = 0; e_schain = 0; e_smxc = 0;
      e_smode = 0; e_srst = 0; e_ksch = 0; e_chain = 0; e_tk1s = 0;
      e_sen = 4'h0; e_round = 6'd0; e_con = 8'h00;
      if (!rst_n) begin
        m_phase = 0; m_cnt = 0; m_round = 0; m_done = 1'b0; m_dec = 1'b0;
      end else begin
        e_done  = m_done;
        e_round = 6'(m_round);
        case (m_phase)
          0: e_srst = bus_if.start;
          1: begin
            e_busy = 1; e_pr = bus_if.pdi_valid;
            e_sen = bus_if.pdi_valid ? 4'hF : 4'h0; e_schain = bus_if.pdi_valid;
          end
          2: begin
            e_busy = 1;
            r = m_cnt / 20; p = m_cnt % 20;
            e_round = 6'(r);
            if (m_dec) begin in_mx = (p < 4); sbi = p - 4; end
            else begin in_mx = (p >= 16); sbi = p; end
            e_sen = 4'hF;
            if (in_mx) e_smxc = 1;
            else begin
              e_schain = 1; e_ksch = 1; e_chain = !m_dec; e_tk1s = (sbi < 8);
              rcv = m_dec ? rc_dec[r] : rc_enc[r];
              if (sbi == 0) e_con = {4'h0, rcv[3:0]};
              else if (sbi == 4) e_con = {6'h00, rcv[5:4]};
              else if (sbi == 8) e_con = 8'h02;
              else e_con = 8'h00;
            end
          end
          3: begin
            e_busy = 1; e_pv = 1;
            e_sen = bus_if.pdo_ready ? 4'hF : 4'h0; e_smode = bus_if.pdo_ready;
          end
          default: ;
        endcase
      end
      chk("busy", bus_if.busy, e_busy);
      chk("done", bus_if.done, e_done);
      chk("pdi_ready", bus_if.pdi_ready, e_pr);
      chk("pdo_valid", bus_if.pdo_valid, e_pv);
      chk("round", round, e_round);
      chk("sen", sen, e_sen);
      chk("schain", schain, e_schain);
      chk("smxc", smxc, e_smxc);
      chk("smode", smode, e_smode);
      chk("srst", srst, e_srst);
      chk("tk1se", tk1se, 1'b0);
      chk("tk_ksch", {tk1ksch, tk2ksch, tk3ksch}, {3{e_ksch}});
      chk("tk_chain", {tk1chain, tk2chain, tk3chain}, {3{e_chain}});
      chk("tk1s", tk1s, e_tk1s);
      chk("con", con, e_con);
`ifdef SKINNY_DEC_EN
      chk("sdec", sdec, e_busy && m_dec);
`endif
      if (rst_n && m_phase == 2) begin
        if (!m_dec) begin
          if (m_cnt == 0)   chk("con_r0_c0", con, 8'h01);
          if (m_cnt == 4)   chk("con_r0_c4", con, 8'h00);
          if (m_cnt == 8)   chk("con_r0_c8", con, 8'h02);
          if (m_cnt == 100) chk("con_r5_c0", con, 8'h0E);
          if (m_cnt == 104) chk("con_r5_c4", con, 8'h03);
          if (m_cnt == 780) chk("con_r39_c0", con, 8'h0A);
          if (m_cnt == 784) chk("con_r39_c4", con, 8'h01);
        end else begin
          if (m_cnt == 4)  chk("dcon_r0_c0", con, 8'h0A);
          if (m_cnt == 8)  chk("dcon_r0_c4", con, 8'h01);
          if (m_cnt == 24) chk("dcon_r1_c0", con, 8'h0D);
          if (m_cnt == 28) chk("dcon_r1_c4", con, 8'h02);
        end
      end
      if (rst_n) begin
        m_done = 1'b0;
        case (m_phase)
          0: if (bus_if.start) begin
            m_phase = 1; m_cnt = 0; m_round = 0; m_dec = DEC_EN && dec_drv;
          end
          1: if (bus_if.pdi_valid) begin
            m_cnt++;
            if (m_cnt == 16) begin m_phase = 2; m_cnt = 0; end
          end
          2: begin
            m_cnt++;
            if (m_cnt == 800) begin m_phase = 3; m_cnt = 0; m_round = 39; end
          end
          3: if (bus_if.pdo_ready) begin
            m_cnt++;
            if (m_cnt == 16) begin m_phase = 0; m_cnt = 0; m_done = 1'b1; end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // vmode: 0 always valid, 1 random, 2 one gap after the first byte
  task automatic run_call(input int vmode, input bit rnd_r, input bit stall15,
                          input bit d, input bit chk_len);
    int t0, stalls;
    bit seen, gapped;
    t0 = cyc_cnt; stalls = 0; seen = 0; gapped = 0;
    bus_if.start = 1'b1; dec_drv = d;
    tick();
    bus_if.start = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      if (vmode == 1) bus_if.pdi_valid = 1'($urandom_range(0, 1));
      else if (vmode == 2 && m_phase == 1 && m_cnt == 1 && !gapped) begin
        bus_if.pdi_valid = 1'b0; gapped = 1;
      end else bus_if.pdi_valid = 1'b1;
      bus_if.pdo_ready = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall15 && m_phase == 3 && m_cnt == 15 && stalls < 3) begin
        bus_if.pdo_ready = 1'b0; stalls++;
      end
      bus_if.start = (m_phase != 0) && ($urandom_range(0, 15) == 0);
      tick();
      if (bus_if.done) seen = 1;
    end
    bus_if.start = 1'b0; bus_if.pdi_valid = 1'b0; bus_if.pdo_ready = 1'b0;
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    else if (chk_len) chk("call_len", 32'(cyc_cnt - t0), 32'd833);
    if (stall15 && seen) chk("stall_cycles", 32'(stalls), 32'd3);
  endtask

  task automatic reset_mid_sb();
    bus_if.start = 1'b1; dec_drv = 1'b0;
    tick();
    bus_if.start = 1'b0; bus_if.pdi_valid = 1'b1; bus_if.pdo_ready = 1'b1;
    for (int i = 0; i < 300 && !(m_phase == 2 && m_cnt == 100); i++) tick();
    chk("rst_reached_sb", 32'(m_phase), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_con", con, 8'h00);
    chk("rst_sen", sen, 4'h0);
    tick(); tick();
    rst_n = 1'b1; bus_if.pdi_valid = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rc_enc[0] = 6'h01;
    for (int i = 1; i < 40; i++)
      rc_enc[i] = {rc_enc[i-1][4:0], rc_enc[i-1][5] ^ rc_enc[i-1][4] ^ 1'b1};
    rc_dec[0] = 6'h1A;
    for (int i = 1; i < 40; i++)
      rc_dec[i] = {rc_dec[i-1][0] ^ rc_dec[i-1][5] ^ 1'b1, rc_dec[i-1][5:1]};
    rst_n = 1'b0; dec_drv = 1'b0;
    bus_if.start = 1'b0; bus_if.pdi_valid = 1'b0; bus_if.pdo_ready = 1'b0;
    chk("model_rc5", rc_enc[5], 6'h3E);
    chk("model_rc39", rc_enc[39], 6'h1A);
    chk("model_drc1", rc_dec[1], 6'h2D);
    repeat (3) tick();
    rst_n = 1'b1;
    tick(); tick();
    run_call(0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_call(2, 1'b0, 1'b1, 1'b0, 1'b0);
    reset_mid_sb();
    run_call(1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_call(1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SKINNY_DEC_EN
    run_call(0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_call(1, 1'b1, 1'b0, 1'b1, 1'b0);
    run_call(0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
